// File: rtl/keccak_perm_arbiter.sv
// keccak_perm_arbiter
//   Shares one Keccak-f[1600] permutation core between N hash/XOF requesters.
//   Round-robin arbitration by default. Define KECCAK_ARB_FIXED_PRIO_EN for
//   fixed priority, where the lowest index wins.
//   The winner's state is latched into perm_in and the core is enabled until
//   perm_valid. The permuted state is then returned on state_out with a
//   one-cycle done pulse to the owner.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req[N]            per-requester level request
//   state_in[N*W]     requester i state on [i*W +: W]
//   gnt[N]            one-hot owner, launch cycle through done cycle
//   done[N]           one-cycle completion pulse to owner
//   state_out[W]      registered permuted state, held until next completion
//   busy              high in RUN and RESP
//   perm_enable       core enable
//   perm_in[W]        registered state to core
//   perm_out[W]       core result
//   perm_valid        core result valid
module keccak_perm_arbiter #(
  parameter int N = 3,
  parameter int W = 1600
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] state_in,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [W-1:0]   state_out,
  output logic           busy,
  output logic           perm_enable,
  output logic [W-1:0]   perm_in,
  input  logic [W-1:0]   perm_out,
  input  logic           perm_valid
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    st;
  logic [IW-1:0] owner;
  logic [IW-1:0] win;

`ifdef KECCAK_ARB_FIXED_PRIO_EN
  // Lowest set index wins; scanning downward leaves the lowest one in win.
  always_comb begin
    win = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[k]) win = IW'(k);
  end
`else
  logic [IW-1:0] rr_ptr;
  logic          found;

  // First set bit searching upward from rr_ptr, wrapping at N.
  always_comb begin : rr_sel
    int j;
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end
`endif

  assign busy = (st != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_IDLE;
      owner       <= '0;
      gnt         <= '0;
      done        <= '0;
      state_out   <= '0;
      perm_enable <= 1'b0;
      perm_in     <= '0;
`ifndef KECCAK_ARB_FIXED_PRIO_EN
      rr_ptr      <= '0;
`endif
    end else begin
      case (st)
        S_IDLE: begin
          if (|req) begin
            owner       <= win;
            gnt         <= N'(1) << win;
            perm_in     <= state_in[int'(win)*W +: W];
            perm_enable <= 1'b1;
            st          <= S_RUN;
          end
        end
        S_RUN: begin
          // perm_in is held so the requester may change state_in freely.
          if (perm_valid) begin
            state_out   <= perm_out;
            done        <= N'(1) << owner;
            perm_enable <= 1'b0;
`ifndef KECCAK_ARB_FIXED_PRIO_EN
            rr_ptr      <= (owner == IW'(N - 1)) ? '0 : owner + IW'(1);
`endif
            st          <= S_RESP;
          end
        end
        S_RESP: begin
          // One cycle with enable low, so the core's round counter clears
          // before the next job. req is ignored here.
          gnt  <= '0;
          done <= '0;
          st   <= S_IDLE;
        end
        default: begin
          gnt         <= '0;
          done        <= '0;
          perm_enable <= 1'b0;
          st          <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/keccak_perm_arbiter.md
# keccak_perm_arbiter

- Shares one Keccak-f[1600] `permutation` core between `N` hash/XOF requesters (SHA3-256, SHA3-512, SHAKE128 matrix expansion, SHAKE256 noise PRF) in the Kyber768 encapsulation datapath.
- Grants the core to one requester at a time, round-robin by default.
- Latches the winner's 1600-bit state, holds the core's `enable` high until `valid`, then returns the permuted state with a one-cycle `done` pulse to the owner.
- Replaces per-hash permutation instances so a single core serves all of pre-encrypt.

## Interface
Parameters:
- `N`, 3: number of requesters (2..8).
- `W`, 1600: Keccak state width. Fixed at 1600; any other value is unsupported.

Ports:
- `clk` in 1: clock. The block uses one clock.
- `rst` in 1: reset, synchronous and active-high.
- `req` in N: per-requester level request.
- `state_in` in N*W: requester i's state on bits `[i*W +: W]`.
- `gnt` out N: one-hot owner indication. High from the launch cycle through the `done` cycle.
- `done` out N: one-cycle pulse to the owner when the result is valid.
- `state_out` out W: registered permuted state. Holds until the next completion.
- `busy` out 1: high in RUN and RESP.
- `perm_enable` out 1: drives core `enable`.
- `perm_in` out W: registered state to core `in`.
- `perm_out` in W: core `state_out`.
- `perm_valid` in 1: core `valid`.

## Operation
- FSM states: IDLE, RUN, RESP.
- **IDLE, some `req` bit set:**
  - Select winner `w`: the first set bit searching upward from `rr_ptr`, wrapping at N.
  - At the clock edge: `owner<=w`, `gnt<=onehot(w)`, `perm_in<=state_in[w]`, `perm_enable<=1`, go to RUN.
- **IDLE, `req==0`:** stay in IDLE.
- **RUN:**
  - `perm_enable` stays 1 and `perm_in` stays stable.
  - On `perm_valid`: `state_out<=perm_out`, `done[owner]<=1`, `perm_enable<=0`, `rr_ptr<=(owner+1) mod N`, go to RESP.
- **RESP:**
  - Lasts one cycle. `done` and `gnt` are high in this cycle.
  - `req` is ignored.
  - Next edge: `gnt<=0`, `done<=0`, go to IDLE.
  - This guarantees at least one cycle with `enable` low between jobs, so the core's round counter resets.
- **Handshake:**
  - A requester must drop `req` by the edge that ends its `done` cycle.
  - A `req` still high when the FSM returns to IDLE is a new job using the current `state_in`. This is how a requester chains multiple squeezes.
- **Boundary cases:**
  - `req` dropped during RUN: the job completes and `done` still pulses.
  - `perm_valid` in IDLE or RESP: ignored.
  - `state_in` changing during RUN: no effect, because `perm_in` is latched.
  - `rr_ptr` wraps from N-1 to 0.
  - Simultaneous requests are resolved solely by `rr_ptr`.

## Timing
- **Reset values:** all outputs 0 (`gnt`, `done`, `busy`, `perm_enable`, `perm_in`, `state_out`); FSM in IDLE; `rr_ptr=0`.
- **Reset mid-operation:** the job is abandoned. No `done` is issued, and `perm_enable` is 0 in the cycle after the reset edge.
- **Latency:**
  - `req` sampled at edge E0, so `perm_enable` is high from cycle E0+1.
  - Core raises `perm_valid` P cycles later.
  - `done` is high in the cycle following the `perm_valid` edge.
- **Overhead:** 2 cycles per job beyond P (the launch edge and RESP).
- **Back-to-back:** a waiting requester launches on the edge leaving the first IDLE cycle after RESP.
- **Starvation bound:** no requester waits more than N-1 jobs.

## Configuration
- Macro: `KECCAK_ARB_FIXED_PRIO_EN`.
- **Defined:** fixed priority, lowest index wins. `rr_ptr` is not implemented, and requester 0 (G/H hash) always preempts queued XOF jobs at arbitration time. Starvation of higher indices is permitted.
- **Undefined (default):** round-robin as specified above.

## Test plan
- **Single request:**
  - Stimulus: N=3, model core P=24. `req=3'b010` with `state_in[1]=1600'h1` at cycle 0.
  - Response: `gnt=3'b010` and `perm_enable=1` from cycle 1; `done=3'b010` for exactly one cycle at cycle 26; `state_out` equals the model f(1).
- **Round-robin:**
  - Stimulus: `req=3'b111` held, each requester dropping its bit on its `done`.
  - Response: grant order 0,1,2. Exactly 2 idle-overhead cycles between consecutive `perm_enable` rises, and `perm_enable` low for at least 1 cycle between jobs.
- **Fixed priority:**
  - Stimulus: `KECCAK_ARB_FIXED_PRIO_EN` defined; `req=3'b110`, then `req[0]` raised during requester 1's RUN.
  - Response: next grant goes to 0, not 2.
- **Chained squeeze:**
  - Stimulus: requester 2 holds `req` for 4 jobs, updating `state_in` from `state_out` on each `done`; other requests idle.
  - Response: 4 `done` pulses; final `state_out` equals f⁴(x).
- **Reset mid-RUN:**
  - Stimulus: `rst` high for 1 cycle at cycle 10 of a job.
  - Response: next cycle shows `perm_enable=0`, `gnt=0`, `busy=0`; no `done` ever for that job; a new `req` afterwards is granted to index 0 (`rr_ptr=0`).
- **Spurious valid and withdrawal:**
  - Stimulus: `perm_valid` pulsed in IDLE; then `req[1]` dropped mid-RUN.
  - Response: the IDLE pulse has no effect; the RUN job still completes with `done[1]=1`.
